mix_tree_sched: RTL and testbench

Controller that sequences one run of a binary diffusion-mixer tree. It opens each leaf inlet valve in turn to load reagent, then enables mixing level by level from the leaves toward the root, then drains the root outlet. It sits between the host command logic and the valve/pump drivers of a `binary_tree_*` mixing network and owns every valve of that tree.

---
 rtl/mix_tree_pkg.sv | 26 ++
 rtl/mix_tree_sched_phase_timer.sv | 38 +++
 rtl/mix_tree_sched.sv | 186 ++++++++++++++++++
 tb/tb_mix_tree_sched.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mix_tree_pkg.sv
// rtl/mix_tree_pkg.sv - shared types and constants for the mixer-tree scheduler
// Purpose: FSM state encoding, default phase lengths and a run-length helper.
// Ports: none (package).
package mix_tree_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MIX,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam int DEF_LEVELS       = 3;
  localparam int DEF_LOAD_CYCLES  = 16;
  localparam int DEF_MIX_CYCLES   = 64;
  localparam int DEF_DRAIN_CYCLES = 32;
  localparam int DEF_CW           = 8;

  // Cycles from the start edge to the done pulse, with pump_ready held high.
  function automatic int run_length(input int levels, input int load_c,
                                    input int mix_c, input int drain_c);
    return (1 << levels) * load_c + levels * mix_c + drain_c + 1;
  endfunction

endpackage

// File: rtl/mix_tree_sched_phase_timer.sv
// rtl/mix_tree_sched_phase_timer.sv - down-counting phase timer
// Purpose: counts the remaining cycles of the current phase.
// Ports: clk, rst_n (sync, active-low), load/load_val (reload),
//        en (count this cycle), expire (last counted cycle of the phase).
module phase_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          expire
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  assign expire = en && (count_q == CW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mix_tree_sched.sv
// rtl/mix_tree_sched.sv - run sequencer for a binary diffusion-mixer tree
// Purpose: loads each leaf inlet in turn, mixes level by level toward the
//          root, drains the outlet, then pulses done. All outputs registered.
// Ports: clk, rst_n (sync, active-low), start, pump_ready,
//        leaf_valve (one-hot inlets), level_mix (one-hot levels, bit 0 = leaf
//        side), out_valve, busy, done.
// Option: MIX_TREE_ABORT_EN adds abort (in) / aborted (out, 1-cycle pulse).
module mix_tree_sched
  import mix_tree_pkg::*;
#(
  parameter int LEVELS       = DEF_LEVELS,
  parameter int LOAD_CYCLES  = DEF_LOAD_CYCLES,
  parameter int MIX_CYCLES   = DEF_MIX_CYCLES,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int CW           = DEF_CW
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef MIX_TREE_ABORT_EN
  input  logic                 abort,
  output logic                 aborted,
`endif
  input  logic                 start,
  input  logic                 pump_ready,
  output logic [2**LEVELS-1:0] leaf_valve,
  output logic [LEVELS-1:0]    level_mix,
  output logic                 out_valve,
  output logic                 busy,
  output logic                 done
);

  localparam int NL = 2 ** LEVELS;
  localparam int IW = LEVELS;
  localparam int LW = (LEVELS > 1) ? $clog2(LEVELS) : 1;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [LW-1:0]   lvl_q, lvl_d;
  logic [NL-1:0]   leaf_valve_q, leaf_valve_d;
  logic [LEVELS-1:0] level_mix_q, level_mix_d;
  logic            out_valve_q, out_valve_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
`ifdef MIX_TREE_ABORT_EN
  logic            aborted_q, aborted_d;
`endif

  logic            tmr_load;
  logic [CW-1:0]   tmr_val;
  logic            tmr_en;
  logic            tmr_expire;

  phase_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    lvl_d        = lvl_q;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    tmr_en       = 1'b0;
    leaf_valve_d = '0;
    level_mix_d  = '0;
    out_valve_d  = 1'b0;
    done_d       = 1'b0;
`ifdef MIX_TREE_ABORT_EN
    aborted_d    = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_LOAD;
          idx_d    = '0;
          tmr_load = 1'b1;
          tmr_val  = CW'(LOAD_CYCLES);
        end
      end
      ST_LOAD: begin
        // Count only cycles in which the inlet was actually open, so a
        // pump_ready dropout stretches the run by exactly its length.
        tmr_en = |leaf_valve_q;
        if (tmr_expire) begin
          tmr_load = 1'b1;
          if (idx_q == IW'(NL - 1)) begin
            state_d = ST_MIX;
            lvl_d   = '0;
            tmr_val = CW'(MIX_CYCLES);
          end else begin
            idx_d   = idx_q + 1'b1;
            tmr_val = CW'(LOAD_CYCLES);
          end
        end
      end
      ST_MIX: begin
        tmr_en = 1'b1;
        if (tmr_expire) begin
          tmr_load = 1'b1;
          if (lvl_q == LW'(LEVELS - 1)) begin
            state_d = ST_DRAIN;
            tmr_val = CW'(DRAIN_CYCLES);
          end else begin
            lvl_d   = lvl_q + 1'b1;
            tmr_val = CW'(MIX_CYCLES);
          end
        end
      end
      ST_DRAIN: begin
        tmr_en = 1'b1;
        if (tmr_expire) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef MIX_TREE_ABORT_EN
    if (abort && ((state_q == ST_LOAD) || (state_q == ST_MIX) ||
                  (state_q == ST_DRAIN))) begin
      state_d   = ST_IDLE;
      aborted_d = 1'b1;
    end
`endif

    // Outputs are decoded from the next state so they appear registered.
    case (state_d)
      ST_LOAD:  leaf_valve_d = pump_ready ? (NL'(1) << idx_d) : '0;
      ST_MIX:   level_mix_d  = LEVELS'(1) << lvl_d;
      ST_DRAIN: out_valve_d  = 1'b1;
      ST_DONE:  done_d       = 1'b1;
      default:  ;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      lvl_q        <= '0;
      leaf_valve_q <= '0;
      level_mix_q  <= '0;
      out_valve_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef MIX_TREE_ABORT_EN
      aborted_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      lvl_q        <= lvl_d;
      leaf_valve_q <= leaf_valve_d;
      level_mix_q  <= level_mix_d;
      out_valve_q  <= out_valve_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef MIX_TREE_ABORT_EN
      aborted_q    <= aborted_d;
`endif
    end
  end

  assign leaf_valve = leaf_valve_q;
  assign level_mix  = level_mix_q;
  assign out_valve  = out_valve_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef MIX_TREE_ABORT_EN
  assign aborted    = aborted_q;
`endif

endmodule

// File: tb/tb_mix_tree_sched.sv
// tb/tb_mix_tree_sched.sv - directed self-checking bench for mix_tree_sched
module tb_mix_tree_sched;
  import mix_tree_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       start_s = 1'b0;
  logic       pump_ready = 1'b1;
  logic [7:0] leaf_valve;
  logic [2:0] level_mix;
  logic       out_valve, busy, done;
  logic [1:0] s_leaf;
  logic       s_mix, s_out, s_busy, s_done;
`ifdef MIX_TREE_ABORT_EN
  logic       abort = 1'b0;
  logic       abort_s = 1'b0;
  logic       aborted, s_aborted;
`endif

  int vectors = 0;
  int miscompares = 0;

  mix_tree_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef MIX_TREE_ABORT_EN
    .abort      (abort),
    .aborted    (aborted),
`endif
    .start      (start),
    .pump_ready (pump_ready),
    .leaf_valve (leaf_valve),
    .level_mix  (level_mix),
    .out_valve  (out_valve),
    .busy       (busy),
    .done       (done)
  );

  mix_tree_sched #(
    .LEVELS(1), .LOAD_CYCLES(1), .MIX_CYCLES(1), .DRAIN_CYCLES(1), .CW(2)
  ) dut_s (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef MIX_TREE_ABORT_EN
    .abort      (abort_s),
    .aborted    (s_aborted),
`endif
    .start      (start_s),
    .pump_ready (pump_ready),
    .leaf_valve (s_leaf),
    .level_mix  (s_mix),
    .out_valve  (s_out),
    .busy       (s_busy),
    .done       (s_done)
  );

  // Expected {leaf[7:0], mix[2:0], out, busy, done} in cycle k+t for the
  // default tree, with an optional inlet dropout of pause_len cycles at pause_at.
  function automatic logic [13:0] exp_def(input int t, input int pause_at,
                                          input int pause_len);
    int u;
    logic [13:0] r;
    r = '0;
    if (t < 1) return r;
    if (pause_len > 0 && t >= pause_at && t < pause_at + pause_len) begin
      r[1] = 1'b1;
      return r;
    end
    u = (pause_len > 0 && t >= pause_at + pause_len) ? t - pause_len : t;
    if (u <= 128) begin
      r[13:6] = 8'(1) << ((u - 1) / 16);
      r[1] = 1'b1;
    end else if (u <= 320) begin
      r[5:3] = 3'(1) << ((u - 129) / 64);
      r[1] = 1'b1;
    end else if (u <= 352) begin
      r[2] = 1'b1;
      r[1] = 1'b1;
    end else if (u == 353) begin
      r[1] = 1'b1;
      r[0] = 1'b1;
    end
    return r;
  endfunction

  task automatic run_default(input string tag, input int pause_at,
                             input int pause_len, input int start_at,
                             input int rst_at, input int abort_at,
                             input int n);
    logic [13:0] obs, e;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int t = 1; t <= n; t++) begin
      @(negedge clk);
      obs = {leaf_valve, level_mix, out_valve, busy, done};
      if (rst_at > 0 && t > rst_at) e = '0;
      else if (abort_at > 0 && t > abort_at) e = '0;
      else e = exp_def(t, pause_at, pause_len);
      vectors++;
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s t=%0d observed %h expected %h", tag, t, obs, e);
      end
`ifdef MIX_TREE_ABORT_EN
      vectors++;
      assert (aborted === (abort_at > 0 && t == abort_at + 1)) else begin
        miscompares++;
        $error("FAIL %s_aborted t=%0d observed %b", tag, t, aborted);
      end
      abort = (abort_at > 0 && t == abort_at);
`endif
      pump_ready = !(pause_len > 0 && t >= pause_at - 1 &&
                     t < pause_at - 1 + pause_len);
      start = (start_at > 0 && t == start_at);
      rst_n = !(rst_at > 0 && t == rst_at);
    end
    start = 1'b0;
    rst_n = 1'b1;
    pump_ready = 1'b1;
`ifdef MIX_TREE_ABORT_EN
    abort = 1'b0;
`endif
  endtask

  logic [5:0] s_exp [0:6];
  logic [5:0] s_obs;
  logic [19:0] rst_obs;

  initial begin
    // reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_obs = {leaf_valve, level_mix, out_valve, busy, done,
               s_leaf, s_mix, s_out, s_busy, s_done};
    vectors++;
    assert (rst_obs === 20'h0) else begin
      miscompares++;
      $error("FAIL reset observed %h expected 0", rst_obs);
    end
    rst_n = 1'b1;
    @(negedge clk);

    run_default("nominal", 0, 0, 0, 0, 0, run_length(3, 16, 64, 32) + 7);
    run_default("pump_pause", 52, 5, 0, 0, 0, 366);
    run_default("start_in_mix", 0, 0, 200, 0, 0, 360);
    run_default("reset_in_drain", 0, 0, 0, 330, 0, 360);
    run_default("after_reset", 0, 0, 0, 0, 0, 360);

    // one-level tree, every phase one cycle long
    s_exp[0] = 6'b010010;
    s_exp[1] = 6'b100010;
    s_exp[2] = 6'b001010;
    s_exp[3] = 6'b000110;
    s_exp[4] = 6'b000011;
    s_exp[5] = 6'b000000;
    s_exp[6] = 6'b000000;
    @(negedge clk);
    start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
    for (int t = 1; t <= 7; t++) begin
      @(negedge clk);
      s_obs = {s_leaf, s_mix, s_out, s_busy, s_done};
      vectors++;
      assert (s_obs === s_exp[t-1]) else begin
        miscompares++;
        $error("FAIL small_tree t=%0d observed %b expected %b", t, s_obs, s_exp[t-1]);
      end
    end

`ifdef MIX_TREE_ABORT_EN
    run_default("abort_mix", 0, 0, 0, 0, 200, 210);
    run_default("after_abort", 0, 0, 0, 0, 0, 360);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
